rc4_key_search_ctrl: RTL

RC4_KEY_SEARCH_CTRL -- requirements
Module: rc4_key_search_ctrl

---
 rtl/rc4_key_search_ctrl_if.sv | 63 ++++++
 rtl/rc4_key_search_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_ctrl_if.sv
// Bundle of the start/done handshakes, the three requester S-memory ports,
// the arbitrated S-memory port and the status of the RC4 key search controller.
interface rc4_key_search_ctrl_if;
    logic        start;
    logic        init_start;
    logic        shuf_start;
    logic        dec_start;
    logic        init_done;
    logic        shuf_done;
    logic        dec_done;
    logic [7:0]  init_address;
    logic [7:0]  shuf_address;
    logic [7:0]  dec_address;
    logic [7:0]  init_data;
    logic [7:0]  shuf_data;
    logic [7:0]  dec_data;
    logic        init_wren;
    logic        shuf_wren;
    logic        dec_wren;
    logic        dec_valid;
    logic [7:0]  s_address;
    logic [7:0]  s_data;
    logic        s_wren;
    logic        sub_reset;
    logic [23:0] secret_key;
    logic        busy;
    logic        key_found;
    logic        key_exhausted;
    logic        error;
    // Current FSM state, exported for observation only.
    logic [3:0]  state;

    // Handshake: each *_start is a one-cycle pulse from the controller; the
    // matching *_done is a level held by the phase block until sub_reset, and
    // is only looked at while the controller sits in that phase's WAIT state.
    modport master (
        input  start,
        input  init_done, shuf_done, dec_done,
        input  init_address, shuf_address, dec_address,
        input  init_data, shuf_data, dec_data,
        input  init_wren, shuf_wren, dec_wren,
        input  dec_valid,
        output init_start, shuf_start, dec_start,
        output s_address, s_data, s_wren,
        output sub_reset, secret_key,
        output busy, key_found, key_exhausted, error,
        output state
    );

    modport slave (
        output start,
        output init_done, shuf_done, dec_done,
        output init_address, shuf_address, dec_address,
        output init_data, shuf_data, dec_data,
        output init_wren, shuf_wren, dec_wren,
        output dec_valid,
        input  init_start, shuf_start, dec_start,
        input  s_address, s_data, s_wren,
        input  sub_reset, secret_key,
        input  busy, key_found, key_exhausted, error,
        input  state
    );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search sequencer: walks secret_key from KEY_MIN to KEY_MAX,
// running init/shuffle/decrypt phases per key and arbitrating the shared S-memory.
module rc4_key_search_ctrl #(
    parameter logic [23:0] KEY_MIN = 24'h000000,
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input logic                   clk,
    input logic                   reset,
    rc4_key_search_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CLR       = 4'd1,
        INIT_GO   = 4'd2,
        INIT_WAIT = 4'd3,
        SHUF_GO   = 4'd4,
        SHUF_WAIT = 4'd5,
        DEC_GO    = 4'd6,
        DEC_WAIT  = 4'd7,
        CHECK     = 4'd8,
        NEXT_KEY  = 4'd9,
        FOUND     = 4'd10,
        EXHAUSTED = 4'd11,
        ERROR     = 4'd12
    } state_t;

    state_t      state;
    state_t      next;
    logic [15:0] wait_cnt;
    logic [23:0] key;
    logic        valid_q;
    logic        busy_q, found_q, exhausted_q, error_q;
    logic        init_start_q, shuf_start_q, dec_start_q, clr_q;
    logic        in_go, in_wait, phase_done, timed_out, can_start;

    assign in_go     = (state == INIT_GO) || (state == SHUF_GO) || (state == DEC_GO);
    assign in_wait   = (state == INIT_WAIT) || (state == SHUF_WAIT) || (state == DEC_WAIT);
    assign timed_out = (wait_cnt == TIMEOUT);
    assign can_start = (state == IDLE) || (state == FOUND) ||
                       (state == EXHAUSTED) || (state == ERROR);

    // Only the done flag of the phase being waited on counts; others are stale.
    always_comb begin
        phase_done = 1'b0;
        case (state)
            INIT_WAIT: phase_done = bus.init_done;
            SHUF_WAIT: phase_done = bus.shuf_done;
            DEC_WAIT:  phase_done = bus.dec_done;
            default:   phase_done = 1'b0;
        endcase
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, FOUND, EXHAUSTED, ERROR: if (bus.start) next = CLR;
            CLR:       next = INIT_GO;
            INIT_GO:   next = INIT_WAIT;
            INIT_WAIT: if (phase_done) next = SHUF_GO; else if (timed_out) next = ERROR;
            SHUF_GO:   next = SHUF_WAIT;
            SHUF_WAIT: if (phase_done) next = DEC_GO;  else if (timed_out) next = ERROR;
            DEC_GO:    next = DEC_WAIT;
            DEC_WAIT:  if (phase_done) next = CHECK;   else if (timed_out) next = ERROR;
            CHECK: begin
                if (valid_q)             next = FOUND;
                else if (key == KEY_MAX) next = EXHAUSTED;
                else                     next = NEXT_KEY;
            end
            NEXT_KEY:  next = CLR;
            default:   next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            key          <= KEY_MIN;
            wait_cnt     <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            error_q      <= 1'b0;
            init_start_q <= 1'b0;
            shuf_start_q <= 1'b0;
            dec_start_q  <= 1'b0;
            clr_q        <= 1'b0;
        end else begin
            state <= next;
            if (in_go)
                wait_cnt <= '0;
            else if (in_wait && !phase_done)
                wait_cnt <= wait_cnt + 16'd1;
            if (can_start && bus.start)
                key <= KEY_MIN;
            else if (state == NEXT_KEY)
                key <= key + 24'd1;
            // dec_valid is only meaningful alongside dec_done, so capture it then.
            if (state == DEC_WAIT && bus.dec_done)
                valid_q <= bus.dec_valid;
            busy_q       <= !((next == IDLE) || (next == FOUND) ||
                              (next == EXHAUSTED) || (next == ERROR));
            found_q      <= (next == FOUND);
            exhausted_q  <= (next == EXHAUSTED);
            error_q      <= (next == ERROR);
            init_start_q <= (next == INIT_GO);
            shuf_start_q <= (next == SHUF_GO);
            dec_start_q  <= (next == DEC_GO);
            clr_q        <= (next == CLR);
        end
    end

    always_comb begin
        bus.s_address = 8'h00;
        bus.s_data    = 8'h00;
        bus.s_wren    = 1'b0;
        case (state)
            INIT_GO, INIT_WAIT: begin
                bus.s_address = bus.init_address;
                bus.s_data    = bus.init_data;
                bus.s_wren    = bus.init_wren;
            end
            SHUF_GO, SHUF_WAIT: begin
                bus.s_address = bus.shuf_address;
                bus.s_data    = bus.shuf_data;
                bus.s_wren    = bus.shuf_wren;
            end
            DEC_GO, DEC_WAIT: begin
                bus.s_address = bus.dec_address;
                bus.s_data    = bus.dec_data;
                bus.s_wren    = bus.dec_wren;
            end
            default: begin
                bus.s_address = 8'h00;
                bus.s_data    = 8'h00;
                bus.s_wren    = 1'b0;
            end
        endcase
    end

    assign bus.sub_reset     = reset | clr_q;
    assign bus.init_start    = init_start_q;
    assign bus.shuf_start    = shuf_start_q;
    assign bus.dec_start     = dec_start_q;
    assign bus.secret_key    = key;
    assign bus.busy          = busy_q;
    assign bus.key_found     = found_q;
    assign bus.key_exhausted = exhausted_q;
    assign bus.error         = error_q;
    assign bus.state         = state;
endmodule
